// File: rtl/fib_bist_seq.sv
// Built-in self-test sequencer for the Fibonacci core: sweeps n_first..n_last,
// checks each core result against an internal golden model. Option: FIB_BIST_TIMEOUT_EN.
module fib_bist_seq #(
  parameter int N_WIDTH        = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int ERR_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_WIDTH-1:0]    n_first,
  input  logic [N_WIDTH-1:0]    n_last,
  output logic                  fib_strobe,
  output logic [N_WIDTH-1:0]    fib_n,
  input  logic                  fib_busy,
  input  logic [DATA_WIDTH-1:0] fib_value,
  output logic                  active,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [N_WIDTH-1:0]    first_fail_n
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    ISSUE,
    GAP,
    WAIT,
    CHECK,
    FIN
  } state_t;

  state_t                state_q;
  logic [N_WIDTH-1:0]    idx_q;
  logic [N_WIDTH-1:0]    last_q;
  logic [N_WIDTH-1:0]    k_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic                  strobe_q;
  logic [N_WIDTH-1:0]    fib_n_q;
  logic                  active_q;
  logic                  done_q;
  logic                  pass_q;
  logic [ERR_WIDTH-1:0]  err_q;
  logic [N_WIDTH-1:0]    first_q;

  logic [DATA_WIDTH-1:0] sum_d;
  logic [ERR_WIDTH-1:0]  err_d;
  logic                  bad_d;

`ifdef FIB_BIST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_err_q;

  assign bad_d = tmo_err_q | (cap_q != a_q);
`else
  assign bad_d = (cap_q != a_q);
`endif

  assign sum_d = a_q + b_q;
  assign err_d = (err_q == '1) ? err_q : err_q + ERR_WIDTH'(1);

  // Golden pair (a,b) always holds (fib(idx), fib(idx+1)) once priming is done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= DATA_WIDTH'(1);
      cap_q    <= '0;
      strobe_q <= 1'b0;
      fib_n_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= '0;
`ifdef FIB_BIST_TIMEOUT_EN
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            last_q   <= n_last;
            idx_q    <= n_first;
            a_q      <= '0;
            b_q      <= DATA_WIDTH'(1);
            k_q      <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
            active_q <= 1'b1;
            if (n_first > n_last) begin
              state_q <= FIN;
            end else if (n_first == '0) begin
              state_q  <= ISSUE;
              strobe_q <= 1'b1;
              fib_n_q  <= n_first;
            end else begin
              state_q <= PRIME;
            end
          end
        end

        // One recurrence step per cycle; leave on the step that reaches idx.
        PRIME: begin
          a_q <= b_q;
          b_q <= sum_d;
          k_q <= k_q + N_WIDTH'(1);
          if (k_q + N_WIDTH'(1) == idx_q) begin
            state_q  <= ISSUE;
            strobe_q <= 1'b1;
            fib_n_q  <= idx_q;
          end
        end

        ISSUE: begin
          strobe_q <= 1'b0;
          state_q  <= GAP;
        end

        GAP: begin
          state_q <= WAIT;
`ifdef FIB_BIST_TIMEOUT_EN
          tmo_q     <= '0;
          tmo_err_q <= 1'b0;
`endif
        end

        WAIT: begin
          if (!fib_busy) begin
            cap_q   <= fib_value;
            state_q <= CHECK;
          end
`ifdef FIB_BIST_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            tmo_err_q <= 1'b1;
            state_q   <= CHECK;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end

        CHECK: begin
          if (bad_d) begin
            err_q <= err_d;
            if (err_q == '0) begin
              first_q <= idx_q;
            end
          end
          if (idx_q == last_q) begin
            state_q <= FIN;
          end else begin
            a_q      <= b_q;
            b_q      <= sum_d;
            idx_q    <= idx_q + N_WIDTH'(1);
            strobe_q <= 1'b1;
            fib_n_q  <= idx_q + N_WIDTH'(1);
            state_q  <= ISSUE;
          end
        end

        FIN: begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
          pass_q   <= (err_q == '0);
          state_q  <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign fib_strobe   = strobe_q;
  assign fib_n        = fib_n_q;
  assign active       = active_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_fail_n = first_q;

endmodule

// File: tb/tb_fib_bist_seq.sv
// Bench for fib_bist_seq: a Fibonacci core model with injectable faults and
// latencies, plus a per-sweep reference of strobes and final verdict.
module tb_fib_bist_seq;

`ifdef FIB_BIST_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1023;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] nFirst = '0;
  logic [7:0] nLast = '0;
  logic       fibStrobe;
  logic [7:0] fibN;
  logic       coreBusy = 1'b0;
  logic [7:0] coreValue = '0;
  logic       active;
  logic       done;
  logic       pass;
  logic [7:0] errCount;
  logic [7:0] firstFailN;

  int assertCount = 0;
  int failCount = 0;

  logic [7:0] faultXor [256];
  int         latArr [256];
  bit         hangArr [256];

  int  expQ [$];
  int  expErr = 0;
  int  expFirst = 0;
  bit  expPass = 1'b0;

  int  cyc = 0;
  bit  rstPrev = 1'b1;
  int  lastN = 0;
  bit  prevDone = 1'b0;
  int  lastStrobeCyc = -100;

  int  coreCnt = 0;
  logic [7:0] pendVal = '0;

  fib_bist_seq #(
    .N_WIDTH(8),
    .DATA_WIDTH(8),
    .ERR_WIDTH(8),
    .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n_first(nFirst),
    .n_last(nLast),
    .fib_strobe(fibStrobe),
    .fib_n(fibN),
    .fib_busy(coreBusy),
    .fib_value(coreValue),
    .active(active),
    .done(done),
    .pass(pass),
    .err_count(errCount),
    .first_fail_n(firstFailN)
  );

  always #5 clk = ~clk;

  // Fibonacci number modulo 256, straight from the definition.
  function automatic logic [7:0] fibMod(input int n);
    int x = 0;
    int y = 1;
    int t;
    for (int i = 0; i < n; i++) begin
      t = (x + y) % 256;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clearFaults();
    for (int i = 0; i < 256; i++) begin
      faultXor[i] = 8'd0;
      latArr[i]   = 3;
      hangArr[i]  = 1'b0;
    end
  endtask

  // Core model: busy for a per-index latency, shows a wrong value while busy.
  always @(posedge clk) begin
    int reqN;
    logic [7:0] resp;
    if (rst) begin
      coreBusy <= 1'b0;
      coreCnt  <= 0;
    end else if (fibStrobe) begin
      reqN = int'(fibN);
      resp = fibMod(reqN) ^ faultXor[reqN];
      if (hangArr[reqN]) begin
        coreBusy  <= 1'b1;
        coreCnt   <= -1;
        coreValue <= ~resp;
      end else if (latArr[reqN] == 0) begin
        coreBusy  <= 1'b0;
        coreValue <= resp;
      end else begin
        coreBusy  <= 1'b1;
        coreCnt   <= latArr[reqN];
        pendVal   <= resp;
        coreValue <= ~resp;
      end
    end else if (coreBusy && coreCnt > 0) begin
      if (coreCnt == 1) begin
        coreBusy  <= 1'b0;
        coreValue <= pendVal;
      end
      coreCnt <= coreCnt - 1;
    end
  end

  always @(posedge clk) rstPrev <= rst;

  // Every-cycle compare of strobes, index stability and the end-of-sweep verdict.
  always @(negedge clk) begin
    cyc++;
    if (rstPrev) begin
      lastN = 0;
      prevDone = 1'b0;
      lastStrobeCyc = -100;
    end else begin
      if (fibStrobe) begin
        checkOutput("strobeSpacing", 32'(cyc - lastStrobeCyc >= 4), 1);
        lastStrobeCyc = cyc;
        checkOutput("strobeQueued", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          checkOutput("strobeIndex", fibN, expQ.pop_front());
        end
        lastN = int'(fibN);
      end else begin
        checkOutput("fibNStable", fibN, lastN);
      end
      if (active) begin
        checkOutput("doneLowWhileActive", done, 0);
      end
      if (done && !prevDone) begin
        checkOutput("sweepPass", pass, expPass);
        checkOutput("sweepErrCount", errCount, expErr);
        checkOutput("sweepFirstFail", firstFailN, expFirst);
        checkOutput("sweepStrobesLeft", expQ.size(), 0);
        checkOutput("sweepActiveLow", active, 0);
      end
      prevDone = done;
    end
  end

  // Runs one sweep; reference is computed from the fault table before starting.
  task automatic applyStimulus(input int nf, input int nl, input bit midStart);
    int cnt = 0;
    int first = 0;
    bit found = 1'b0;
    int k;
    expQ.delete();
    for (int i = nf; i <= nl; i++) begin
      expQ.push_back(i);
      if (hangArr[i] || faultXor[i] != 8'd0) begin
        cnt++;
        if (!found) begin
          first = i;
          found = 1'b1;
        end
      end
    end
    expErr   = (cnt > 255) ? 255 : cnt;
    expFirst = first;
    expPass  = (cnt == 0);
    nFirst = 8'(nf);
    nLast  = 8'(nl);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    checkOutput("activeAfterStart", active, 1);
    if (nf <= nl) begin
      while (!fibStrobe && k < 2000) begin
        @(negedge clk);
        k++;
      end
      checkOutput("primeLatency", k, nf + 1);
      if (midStart) begin
        repeat (3) @(negedge clk);
        nFirst = 8'd7;
        nLast  = 8'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    while (!done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("doneReached", done, 1);
    if (nf > nl) begin
      checkOutput("reversedDoneLatency", k, 2);
    end
    @(negedge clk);
    checkOutput("doneHeld", done, 1);
    checkOutput("activeLowAfterDone", active, 0);
  endtask

  task automatic resetMidWait();
    int k = 0;
    clearFaults();
    latArr[2]   = 30;
    faultXor[1] = 8'h40;
    expQ.delete();
    for (int i = 0; i <= 4; i++) expQ.push_back(i);
    nFirst = 8'd0;
    nLast  = 8'd4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (errCount != 8'd1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput("midErrSeen", errCount, 1);
    repeat (6) @(negedge clk);
    checkOutput("midStillActive", active, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    checkOutput("rstStrobe", fibStrobe, 0);
    checkOutput("rstActive", active, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErrCount", errCount, 0);
    checkOutput("rstFirstFail", firstFailN, 0);
    checkOutput("rstFibN", fibN, 0);
    clearFaults();
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearFaults();
    $display("[TB] starting fib_bist_seq bench (timeout=%0d)", TB_TMO);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("resetStrobe", fibStrobe, 0);
    checkOutput("resetFibN", fibN, 0);
    checkOutput("resetActive", active, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetPass", pass, 0);
    checkOutput("resetErrCount", errCount, 0);
    checkOutput("resetFirstFail", firstFailN, 0);

    checkOutput("modelFib9", fibMod(9), 34);
    checkOutput("modelFib10", fibMod(10), 55);
    checkOutput("modelFib14", fibMod(14), 121);

    $display("[TB] basic sweep 0..9");
    applyStimulus(0, 9, 1'b0);
    checkOutput("basicPass", pass, 1);
    checkOutput("basicErr", errCount, 0);

    $display("[TB] fault at n=10, sweep 0..12");
    faultXor[10] = fibMod(10) ^ 8'd56;
    applyStimulus(0, 12, 1'b0);
    checkOutput("faultErr", errCount, 1);
    checkOutput("faultFirst", firstFailN, 10);
    checkOutput("faultPass", pass, 0);
    clearFaults();

    $display("[TB] priming sweep 14..14");
    applyStimulus(14, 14, 1'b0);
    checkOutput("primePass", pass, 1);

    $display("[TB] reversed range 5..3");
    applyStimulus(5, 3, 1'b0);
    checkOutput("reversedPass", pass, 1);
    checkOutput("reversedErr", errCount, 0);

    $display("[TB] start ignored mid-sweep 0..4");
    applyStimulus(0, 4, 1'b1);
    checkOutput("ignorePass", pass, 1);

`ifdef FIB_BIST_TIMEOUT_EN
    $display("[TB] timeout on n=2, sweep 0..3");
    hangArr[2] = 1'b1;
    applyStimulus(0, 3, 1'b0);
    checkOutput("timeoutErr", errCount, 1);
    checkOutput("timeoutFirst", firstFailN, 2);
    checkOutput("timeoutPass", pass, 0);
    clearFaults();
`endif

    $display("[TB] reset during WAIT");
    resetMidWait();
    applyStimulus(0, 4, 1'b0);
    checkOutput("afterResetPass", pass, 1);
    checkOutput("afterResetErr", errCount, 0);

    $display("[TB] top-of-range sweep 253..255");
    faultXor[255] = 8'h01;
    applyStimulus(253, 255, 1'b0);
    checkOutput("topFirst", firstFailN, 255);
    clearFaults();

    $display("[TB] error counter saturation, sweep 0..255");
    for (int i = 0; i < 256; i++) begin
      faultXor[i] = 8'h80;
      latArr[i]   = 0;
    end
    applyStimulus(0, 255, 1'b0);
    checkOutput("satErr", errCount, 255);
    clearFaults();

    $display("[TB] randomized sweeps");
    for (int s = 0; s < 12; s++) begin
      int nf;
      int nl;
      nf = int'($urandom_range(0, 40));
      if (nf > 0 && $urandom_range(0, 5) == 0) begin
        nl = int'($urandom_range(0, nf - 1));
      end else begin
        nl = nf + int'($urandom_range(0, 12));
      end
      for (int i = nf; i <= nl; i++) begin
        faultXor[i] = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        latArr[i]   = int'($urandom_range(0, 5));
      end
      applyStimulus(nf, nl, 1'b0);
      clearFaults();
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fib_bist_seq.md
Name: fib_bist_seq

Overview:
Initiator-side sequencer and checker for the Fibonacci core's strobe/busy request interface. On start it sweeps the index n from n_first to n_last. For each index it issues a one-cycle strobe with n, waits for busy to drop, captures the returned value and compares it with an internally generated golden Fibonacci number. It sits beside the Fibonacci core as a built-in self-test engine and reports pass/fail, an error count and the first failing index.

Parameters:
N_WIDTH, 8, width of index n and of n_first/n_last/fib_n/first_fail_n
DATA_WIDTH, 8, width of fib_value and golden model; arithmetic is modulo 2^DATA_WIDTH
ERR_WIDTH, 8, width of err_count (saturating)
TIMEOUT_CYCLES, 1023, max cycles busy may stay high per request (used only with FIB_BIST_TIMEOUT_EN)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a sweep; ignored while active=1
n_first  in  N_WIDTH  first index of sweep, sampled on accepted start
n_last  in  N_WIDTH  last index (inclusive), sampled on accepted start
fib_strobe  out  1  request strobe to core, high exactly one cycle per request
fib_n  out  N_WIDTH  index presented to core; stable from strobe until next strobe
fib_busy  in  1  core busy
fib_value  in  DATA_WIDTH  core result, valid when fib_busy=0 after a request
active  out  1  sweep in progress
done  out  1  level; set at sweep end, cleared on next accepted start or rst
pass  out  1  valid when done=1; 1 if err_count==0
err_count  out  ERR_WIDTH  mismatches (and timeouts) this sweep, saturates at all-ones
first_fail_n  out  N_WIDTH  index of first error; 0 if none

Behaviour:
- Reset (rst=1 at edge): state IDLE; fib_strobe=0, fib_n=0, active=0, done=0, pass=0, err_count=0, first_fail_n=0; golden regs a=0, b=1. Reset mid-sweep aborts at that edge; strobe never extends.
- All inputs sampled on clk; all outputs registered.
- States: IDLE, PRIME, ISSUE, GAP, WAIT, CHECK, FIN.
- IDLE: on start: latch n_first/n_last; set idx=n_first, a=0, b=1, k=0; clear done/pass/err_count/first_fail_n; set active=1; go PRIME.
- n_first > n_last: on start go straight to FIN (no strobes); done=1, pass=1.
- PRIME: while k<idx: a<=b, b<=a+b (mod 2^DATA_WIDTH), k++. One step per cycle, so exactly n_first cycles. When k==idx go ISSUE. Invariant: a=fib(idx), with fib(0)=0, fib(1)=1.
- ISSUE: fib_strobe=1 and fib_n=idx for exactly one cycle; go GAP.
- GAP: fib_strobe=0; one cycle, busy not sampled; go WAIT.
- WAIT: if fib_busy=0, capture fib_value and go CHECK; else stay.
- CHECK: if captured != a: err_count++ (saturating); if this is the first error, first_fail_n=idx. Then:
  - if idx==n_last, go FIN;
  - else a<=b, b<=a+b, idx++, go ISSUE.
- Minimum spacing between strobes: 4 cycles (ISSUE, GAP, WAIT with busy already low, CHECK).
- idx==2^N_WIDTH-1 with n_last at the same value: sweep terminates at CHECK; idx never wraps.
- FIN: active=0, done=1, pass=(err_count==0); go IDLE.
- start during active=1: ignored. start in the same cycle as rst: rst wins.

Optional Feature:
FIB_BIST_TIMEOUT_EN
- Defined: WAIT keeps a cycle counter, cleared on entry to WAIT. If fib_busy is still 1 after TIMEOUT_CYCLES WAIT cycles, the request counts as an error: err_count++, first_fail_n updated if first error. The sequencer then advances exactly as CHECK does; the current fib_value is not compared.
- Undefined: no counter; WAIT holds indefinitely while busy=1.

Test Plan:
- Basic sweep: core model with 3-cycle busy; start with n_first=0, n_last=9 -> 10 strobes with fib_n 0..9, captured values 0,1,1,2,3,5,8,13,21,34; done=1, pass=1, err_count=0.
- Fault injection: model returns 56 for n=10; sweep 0..12 -> err_count=1, first_fail_n=10, pass=0.
- Priming and wrap: n_first=n_last=14 -> 14 PRIME cycles then a single strobe with fib_n=14; expects 121 (377 mod 256); pass=1 with a correct model.
- Reversed range and busy-ignore: n_first=5, n_last=3 -> no strobe, done=1, pass=1. Then start pulsed again mid-sweep of 0..4 -> ignored, exactly 5 strobes.
- Timeout (macro defined, TIMEOUT_CYCLES=16): busy held high for n=2 in sweep 0..3 -> err_count=1, first_fail_n=2, remaining indices checked, pass=0.
- Reset mid-WAIT: assert rst for one cycle -> next cycle fib_strobe=0, active=0, done=0, err_count=0; a subsequent start 0..4 runs clean.
